// File: rtl/ssc_dsd_pkg.sv
// SSC-DSD shared types and GF(2^8) helpers.
// Used by both encoder and decoder sides.
package ssc_dsd_pkg;

  typedef logic [7:0] sym_t;

  localparam sym_t GF_POLY = 8'h1D;
  localparam int   SSC_K   = 8;

  typedef enum logic {
    COLLECT,
    OUT
  } state_t;

  function automatic sym_t gf_mul_alpha(sym_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/ssc_dsd_parity_acc.sv
// SSC-DSD parity accumulators.
// Horner form: acc1 = acc1*alpha ^ sym per beat.
module ssc_dsd_parity_acc
  import ssc_dsd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       zero,
  input  logic       en,
  input  logic [7:0] sym,
  output logic [7:0] acc0,
  output logic [7:0] acc1
);

  // P0 is a plain XOR; P1 folds in alpha once per beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc0 <= '0;
      acc1 <= '0;
    end else if (zero) begin
      acc0 <= '0;
      acc1 <= '0;
    end else if (en) begin
      acc0 <= acc0 ^ sym;
      acc1 <= gf_mul_alpha(acc1) ^ sym;
    end
  end

endmodule

// File: rtl/ssc_dsd_encoder.sv
// Streaming SSC-DSD encoder: K data beats in,
// one codeword with P0/P1 parity out.
module ssc_dsd_encoder
  import ssc_dsd_pkg::*;
#(
  parameter int K     = SSC_K,
  parameter int SYM_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [7:0]     in_sym,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [8*K-1:0] out_data,
  output logic [7:0]     out_p0,
  output logic [7:0]     out_p1
);

  localparam int CW = $clog2(K);
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  if (SYM_W != 8) begin : g_bad_symw
    $error("ssc_dsd_encoder: SYM_W must be 8");
  end
  if (K < 2 || K > 16) begin : g_bad_k
    $error("ssc_dsd_encoder: K must be 2..16");
  end

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt;
  logic [8*K-1:0]  data_q;
  logic            accept;
  logic            done;
  logic            zero;

  assign accept = in_ready & in_valid & ~clear;
  assign done   = out_valid & out_ready;
  assign zero   = done | (clear & in_ready);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nx;
  end

  // next state: leave COLLECT on last beat, OUT on handshake
  always_comb begin
    state_nx = state;
    unique case (state)
      COLLECT: if (accept && cnt == LAST) state_nx = OUT;
      OUT:     if (out_ready) state_nx = COLLECT;
      default: state_nx = COLLECT;
    endcase
  end

  // handshake outputs decode straight from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      COLLECT: in_ready  = 1'b1;
      OUT:     out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // beat counter, wraps on the last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (zero) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // first beat shifts up to d_{K-1}, last lands at d_0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (accept) begin
      data_q <= {data_q[8*K-9:0], in_sym};
    end
  end

  ssc_dsd_parity_acc u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .zero  (zero),
    .en    (accept),
    .sym   (in_sym),
    .acc0  (out_p0),
    .acc1  (out_p1)
  );

  assign out_data = data_q;

endmodule
